// File: rtl/sound_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sound_scheduler_if : frame tick, event requests and speaker status bundle
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
interface sound_scheduler_if #(
   parameter int NUM_SOURCES = 6
) ();
   localparam int SRC_W = $clog2(NUM_SOURCES);

   logic                   vSyncStart;
   logic [NUM_SOURCES-1:0] request;
   logic                   mute;
   logic                   speaker;
   logic                   busy;
   logic [SRC_W-1:0]       activeSource;
   logic [NUM_SOURCES-1:0] pending;

   modport master (
      output vSyncStart, request, mute,
      input  speaker, busy, activeSource, pending
   );

   modport slave (
      input  vSyncStart, request, mute,
      output speaker, busy, activeSource, pending
   );
endinterface
`default_nettype wire

// File: rtl/sound_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sound_scheduler : fixed-priority sharing of one speaker between collision events
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module sound_scheduler #(
   parameter int                                 NUM_SOURCES  = 6,
   parameter int                                 HP_WIDTH     = 16,
   parameter logic [NUM_SOURCES*HP_WIDTH-1:0]    HALF_PERIODS = {6{16'd28608}},
   parameter int                                 DUR_WIDTH    = 4,
   parameter logic [NUM_SOURCES*DUR_WIDTH-1:0]   DURATIONS    = {6{4'd6}},
   parameter int                                 GAP_FRAMES   = 2
) (
   input  logic              pixelClock,
   input  logic              reset,
   sound_scheduler_if.slave  bus
);
   localparam int SRC_W    = $clog2(NUM_SOURCES);
   localparam int GAP_W    = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;
   localparam int GAP_LAST = (GAP_FRAMES > 0) ? GAP_FRAMES - 1 : 0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [1:0]             state;
   logic [1:0]             state_next;
   logic [SRC_W-1:0]       active_src;
   logic [SRC_W-1:0]       winner;
   logic [HP_WIDTH-1:0]    tone_cnt;
   logic [DUR_WIDTH-1:0]   frames;
   logic [GAP_W-1:0]       gap_cnt;
   logic                   speaker_reg;
   logic [NUM_SOURCES-1:0] pending_reg;
   logic [NUM_SOURCES-1:0] pending_next;
   logic [NUM_SOURCES-1:0] merge_mask;
   logic [NUM_SOURCES-1:0] grant_mask;
   logic [HP_WIDTH-1:0]    hp_limit [NUM_SOURCES];
   logic [DUR_WIDTH-1:0]   dur_load [NUM_SOURCES];
   logic                   grant;
   logic                   tone_end;
   logic                   gap_end;
   logic                   tone_wrap;
   logic                   busy_w;

   // Zero half-periods and zero durations behave as one.
   generate
      for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
         localparam logic [HP_WIDTH-1:0]  HP  = HALF_PERIODS[i*HP_WIDTH +: HP_WIDTH];
         localparam logic [DUR_WIDTH-1:0] DUR = DURATIONS[i*DUR_WIDTH +: DUR_WIDTH];
         assign hp_limit[i] = (HP == '0) ? '0 : HP - HP_WIDTH'(1);
         assign dur_load[i] = (DUR == '0) ? DUR_WIDTH'(1) : DUR;
      end
   endgenerate

   always_comb begin
      winner = '0;
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (pending_reg[i]) winner = SRC_W'(i);
      end
   end

   always_ff @(posedge pixelClock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (|pending_reg) state_next = S_PLAY;
         S_PLAY:  if (tone_end) state_next = (GAP_FRAMES == 0) ? S_IDLE : S_GAP;
         S_GAP:   if (gap_end) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      grant     = (state == S_IDLE) && (|pending_reg);
      tone_end  = (state == S_PLAY) && bus.vSyncStart && (frames == DUR_WIDTH'(1));
      gap_end   = (state == S_GAP) && bus.vSyncStart && (gap_cnt == GAP_W'(GAP_LAST));
      tone_wrap = (state == S_PLAY) && (tone_cnt == hp_limit[active_src]);
      busy_w    = (state != S_IDLE);
   end

   // Repeat events for the tone already sounding merge into it; a request on
   // the grant edge re-arms the granted bit.
   always_comb begin
      merge_mask   = (state == S_PLAY) ? (NUM_SOURCES'(1) << active_src) : '0;
      grant_mask   = grant ? (NUM_SOURCES'(1) << winner) : '0;
      pending_next = (pending_reg & ~grant_mask) | (bus.request & ~merge_mask);
   end

   always_ff @(posedge pixelClock or posedge reset) begin
      if (reset) begin
         pending_reg <= '0;
         active_src  <= '0;
         tone_cnt    <= '0;
         frames      <= '0;
         gap_cnt     <= '0;
         speaker_reg <= 1'b0;
      end else begin
         pending_reg <= pending_next;
         case (state)
            S_IDLE: begin
               if (grant) begin
                  active_src  <= winner;
                  tone_cnt    <= '0;
                  speaker_reg <= 1'b0;
                  frames      <= dur_load[winner];
               end
            end
            S_PLAY: begin
               if (tone_end) begin
                  speaker_reg <= 1'b0;
                  tone_cnt    <= '0;
                  frames      <= '0;
                  gap_cnt     <= '0;
               end else begin
                  if (tone_wrap) begin
                     tone_cnt    <= '0;
                     speaker_reg <= ~speaker_reg;
                  end else begin
                     tone_cnt <= tone_cnt + HP_WIDTH'(1);
                  end
                  if (bus.vSyncStart) frames <= frames - DUR_WIDTH'(1);
               end
            end
            S_GAP: begin
               speaker_reg <= 1'b0;
               if (bus.vSyncStart) gap_cnt <= gap_cnt + GAP_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.speaker      = speaker_reg & ~bus.mute;
   assign bus.busy         = busy_w;
   assign bus.activeSource = active_src;
   assign bus.pending      = pending_reg;

endmodule
`default_nettype wire
